turbo_iter_sched: RTL and testbench

Iteration scheduler for the turbo decoder's single shared BCJR max-product SISO core. Accepts one frame at a time, sequences the core through alternating half-iterations: decoder 1 in natural order without extrinsic on the first pass, then decoder 2 in interleaved order with extrinsic. It steers the ping-pong extrinsic banks, applies early termination and a per-half-iteration watchdog, and reports iteration count and status per frame. It sits between the frame buffer front end and the SISO core.

---
 rtl/turbo_iter_sched.sv | 203 ++++++++++++++++++++
 tb/tb_turbo_iter_sched.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/turbo_iter_sched.sv
// Turbo decoder iteration scheduler: drives the shared SISO core through alternating
// half-iterations with ping-pong extrinsic banks, early termination and a watchdog.
module turbo_iter_sched #(
  parameter int MAX_ITER = 8,
  parameter int MIN_ITER = 2,
  parameter int TIMEOUT  = 4096,
  parameter int ITER_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_valid,
  output logic              frame_ready,
  input  logic              flush,
  output logic              core_start,
  output logic              core_half,
  output logic              core_use_ext,
  output logic              ext_rd_bank,
  output logic              ext_wr_bank,
  output logic              core_abort,
  input  logic              core_done,
  input  logic              core_hd_stable,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ITER_W-1:0] out_iters,
  output logic              out_early,
  output logic              out_err
);

  localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_OUT   = 3'd4;

  localparam logic [ITER_W-1:0] MIN_N = ITER_W'(MIN_ITER);
  localparam logic [ITER_W-1:0] MAX_N = ITER_W'(MAX_ITER);
  localparam logic [WD_W-1:0]   WD_LAST = WD_W'(TIMEOUT - 1);

  logic [2:0]        state_q, state_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic              half_q, half_d;
  logic [WD_W-1:0]   wdog_q, wdog_d;
  logic              stable_q, stable_d;
  logic              chalf_q, chalf_d;
  logic              use_ext_q, use_ext_d;
  logic              rd_bank_q, rd_bank_d;
  logic              wr_bank_q, wr_bank_d;
  logic [ITER_W-1:0] iters_q, iters_d;
  logic              early_q, early_d;
  logic              err_q, err_d;

  logic              load_start;
  logic              go_idle;
  logic [ITER_W-1:0] n_iter;

  assign n_iter = iter_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    iter_d     = iter_q;
    half_d     = half_q;
    wdog_d     = wdog_q;
    stable_d   = stable_q;
    iters_d    = iters_q;
    early_d    = early_q;
    err_d      = err_q;
    core_abort = 1'b0;
    load_start = 1'b0;
    go_idle    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (frame_valid) begin
          iter_d     = '0;
          half_d     = 1'b0;
          load_start = 1'b1;
          state_d    = S_START;
        end
      end
      S_START: begin
        if (flush) begin
          core_abort = 1'b1;
          go_idle    = 1'b1;
        end else begin
          wdog_d  = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // flush beats core_done, and core_done beats the watchdog in the same cycle
        if (flush) begin
          core_abort = 1'b1;
          go_idle    = 1'b1;
        end else if (core_done) begin
          stable_d = core_hd_stable;
          state_d  = S_CHECK;
        end else if (wdog_q == WD_LAST) begin
          core_abort = 1'b1;
          err_d      = 1'b1;
          early_d    = 1'b0;
          iters_d    = iter_q;
          state_d    = S_OUT;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      S_CHECK: begin
        if (flush) begin
          go_idle = 1'b1;
        end else if (!half_q) begin
          half_d     = 1'b1;
          load_start = 1'b1;
          state_d    = S_START;
        end else if ((stable_q && (n_iter >= MIN_N)) || (n_iter == MAX_N)) begin
          iters_d = n_iter;
          early_d = (n_iter < MAX_N);
          err_d   = 1'b0;
          state_d = S_OUT;
        end else begin
          iter_d     = n_iter;
          half_d     = 1'b0;
          load_start = 1'b1;
          state_d    = S_START;
        end
      end
      S_OUT: begin
        if (flush || out_ready) go_idle = 1'b1;
      end
      default: go_idle = 1'b1;
    endcase

    // Core steering is captured on START entry so it holds through CHECK.
    chalf_d   = chalf_q;
    use_ext_d = use_ext_q;
    rd_bank_d = rd_bank_q;
    wr_bank_d = wr_bank_q;
    if (load_start) begin
      chalf_d   = half_d;
      use_ext_d = (iter_d != '0) || half_d;
      wr_bank_d = half_d;
      rd_bank_d = ~half_d;
    end

    if (go_idle) begin
      state_d   = S_IDLE;
      iter_d    = '0;
      half_d    = 1'b0;
      wdog_d    = '0;
      stable_d  = 1'b0;
      chalf_d   = 1'b0;
      use_ext_d = 1'b0;
      rd_bank_d = 1'b0;
      wr_bank_d = 1'b0;
      iters_d   = '0;
      early_d   = 1'b0;
      err_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      iter_q    <= '0;
      half_q    <= 1'b0;
      wdog_q    <= '0;
      stable_q  <= 1'b0;
      chalf_q   <= 1'b0;
      use_ext_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_bank_q <= 1'b0;
      iters_q   <= '0;
      early_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      iter_q    <= iter_d;
      half_q    <= half_d;
      wdog_q    <= wdog_d;
      stable_q  <= stable_d;
      chalf_q   <= chalf_d;
      use_ext_q <= use_ext_d;
      rd_bank_q <= rd_bank_d;
      wr_bank_q <= wr_bank_d;
      iters_q   <= iters_d;
      early_q   <= early_d;
      err_q     <= err_d;
    end
  end

  assign frame_ready  = (state_q == S_IDLE);
  assign core_start   = (state_q == S_START);
  assign out_valid    = (state_q == S_OUT);
  assign core_half    = chalf_q;
  assign core_use_ext = use_ext_q;
  assign ext_rd_bank  = rd_bank_q;
  assign ext_wr_bank  = wr_bank_q;
  assign out_iters    = iters_q;
  assign out_early    = early_q;
  assign out_err      = err_q;

endmodule

// File: tb/tb_turbo_iter_sched.sv
// Randomized frame plans drive a core stand-in; a plan-level model predicts each
// frame result into a queue that a separate output monitor pops and compares.
module tb_turbo_iter_sched;
  localparam int MAXI = 4;
  localparam int MINI = 2;
  localparam int TO   = 16;
  localparam int IW   = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic frame_valid = 1'b0, flush = 1'b0, core_done = 1'b0, core_hd_stable = 1'b0;
  logic out_ready = 1'b0;
  logic frame_ready, core_start, core_half, core_use_ext, ext_rd_bank, ext_wr_bank;
  logic core_abort, out_valid, out_early, out_err;
  logic [IW-1:0] out_iters;

  turbo_iter_sched #(.MAX_ITER(MAXI), .MIN_ITER(MINI), .TIMEOUT(TO), .ITER_W(IW)) dut (
    .clk(clk), .rst_n(rst_n), .frame_valid(frame_valid), .frame_ready(frame_ready),
    .flush(flush), .core_start(core_start), .core_half(core_half),
    .core_use_ext(core_use_ext), .ext_rd_bank(ext_rd_bank), .ext_wr_bank(ext_wr_bank),
    .core_abort(core_abort), .core_done(core_done), .core_hd_stable(core_hd_stable),
    .out_valid(out_valid), .out_ready(out_ready), .out_iters(out_iters),
    .out_early(out_early), .out_err(out_err));

  always #5 clk = ~clk;

  typedef struct { int iters; bit early; bit err; } res_t;
  res_t exp_q[$];

  int n_tests = 0, n_fail = 0;

  // frame plan
  bit stab[16];
  int dly[16];
  int to_idx, fl_idx, rst_idx, bp;
  bit fl_done;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic make_plan(input int mode);
    for (int i = 0; i < 16; i++) begin
      stab[i] = ($urandom_range(0, 3) == 0);
      dly[i]  = $urandom_range(0, 15);
    end
    to_idx = -1; fl_idx = -1; rst_idx = -1; fl_done = 1'b0;
    bp = $urandom_range(0, 10);
    case (mode)
      1: begin for (int i = 0; i < 16; i++) stab[i] = 1'b0; bp = 10; end
      2: for (int i = 0; i < 16; i++) stab[i] = 1'b1;
      3: begin for (int i = 0; i < 16; i++) stab[i] = 1'b0; to_idx = 2; end
      4: begin fl_idx = 1; fl_done = 1'b1; dly[1] = 5; end
      5: for (int i = 0; i < 16; i++) dly[i] = 15;
      6: begin for (int i = 0; i < 16; i++) stab[i] = 1'b0; rst_idx = 1; end
      7: begin fl_idx = $urandom_range(0, 7); fl_done = 1'b0; end
      default: begin
        if ($urandom_range(0, 4) == 0) to_idx = $urandom_range(0, 2 * MAXI - 1);
        if ($urandom_range(0, 5) == 0) begin
          fl_idx = $urandom_range(0, 2 * MAXI - 1);
          fl_done = 1'($urandom_range(0, 1));
        end
      end
    endcase
  endtask

  task automatic run_frame();
    int nh, kind, n, cnt;
    res_t r;
    // reference: walk iterations/halves straight from the scheduling rules
    nh = 0; kind = 0; r = '{0, 1'b0, 1'b0};
    for (int idx = 0; idx < 2 * MAXI; idx++) begin
      nh++;
      if (idx == fl_idx || idx == rst_idx) begin kind = 2; break; end
      if (idx == to_idx) begin kind = 1; r = '{idx / 2, 1'b0, 1'b1}; break; end
      if (idx % 2 == 1) begin
        n = idx / 2 + 1;
        if ((stab[idx] && n >= MINI) || n == MAXI) begin
          r = '{n, (n < MAXI), 1'b0}; break;
        end
      end
    end

    cnt = 0;
    while (!frame_ready && cnt < 100) begin
      core_done = 1'($urandom_range(0, 1));
      core_hd_stable = 1'($urandom_range(0, 1));
      tick(); cnt++;
    end
    core_done = 1'b0;
    chk("idle_wait", frame_ready, 1);
    core_done = 1'b1; core_hd_stable = 1'b1;
    tick(); core_done = 1'b0;
    chk("idle_spurious", {frame_ready, core_start}, 2'b10);

    if (kind != 2) exp_q.push_back(r);
    frame_valid = 1'b1; tick(); frame_valid = 1'b0;

    for (int idx = 0; idx < nh; idx++) begin
      bit h;
      h = 1'(idx % 2);
      chk("start", {core_start, core_half, core_use_ext, ext_wr_bank, ext_rd_bank},
          {1'b1, h, (idx != 0), h, ~h});
      tick();
      chk("start_pulse", {core_start, core_abort}, 2'b00);
      if (idx == rst_idx) begin
        tick(); #2 rst_n = 1'b0; #1;
        chk("async_rst", {frame_ready, core_start, core_half, core_use_ext, ext_rd_bank,
            ext_wr_bank, core_abort, out_valid, out_early, out_err, out_iters},
            {1'b1, 13'd0});
        @(posedge clk); #1 rst_n = 1'b1;
        tick();
        return;
      end else if (idx == fl_idx) begin
        repeat (dly[idx]) tick();
        flush = 1'b1; core_done = fl_done; core_hd_stable = 1'b1;
        #1 chk("flush_abort", core_abort, 1);
        tick(); flush = 1'b0; core_done = 1'b0;
        chk("flush_idle", {frame_ready, out_valid, core_abort}, 3'b100);
        tick();
        chk("flush_noout", {frame_ready, out_valid}, 2'b10);
        return;
      end else if (idx == to_idx) begin
        repeat (TO - 2) tick();
        chk("wd_early", core_abort, 0);
        tick();
        chk("wd_abort", core_abort, 1);
        tick();
        chk("wd_out", {out_valid, core_abort}, 2'b10);
      end else begin
        repeat (dly[idx]) tick();
        core_done = 1'b1; core_hd_stable = stab[idx];
        tick(); core_done = 1'b0; core_hd_stable = 1'($urandom_range(0, 1));
        chk("check_cycle", {core_start, core_abort, out_valid}, 3'b000);
        tick();
        if (idx == nh - 1) chk("out_latency", out_valid, 1);
      end
    end
  endtask

  // downstream sink: variable backpressure per result
  initial begin
    forever begin
      tick();
      if (out_valid && rst_n) begin
        out_ready = 1'b0;
        repeat (bp) tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
      end
    end
  end

  // output monitor / scoreboard
  bit held = 1'b0;
  logic [IW+1:0] prev;
  always @(negedge clk) begin
    if (!rst_n) held <= 1'b0;
    else if (out_valid) begin
      chk("out_frame_ready", frame_ready, 0);
      if (held) chk("out_hold", {out_iters, out_early, out_err}, prev);
      if (out_ready) begin
        held <= 1'b0;
        if (exp_q.size() == 0) chk("sb_unexpected", 1, 0);
        else begin
          res_t e;
          e = exp_q.pop_front();
          chk("out_result", {out_iters, out_early, out_err},
              {IW'(e.iters), e.early, e.err});
        end
      end else begin
        held <= 1'b1;
        prev <= {out_iters, out_early, out_err};
      end
    end else held <= 1'b0;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  initial begin
    #23;
    chk("reset_state", {frame_ready, core_start, core_half, core_use_ext, ext_rd_bank,
        ext_wr_bank, core_abort, out_valid, out_early, out_err, out_iters},
        {1'b1, 13'd0});
    @(posedge clk); #1 rst_n = 1'b1;
    tick();
    for (int m = 1; m <= 7; m++) begin make_plan(m); run_frame(); end
    make_plan(0); run_frame();
    for (int f = 0; f < 40; f++) begin make_plan(0); run_frame(); end
    make_plan(6); run_frame();
    make_plan(2); run_frame();
    repeat (30) tick();
    chk("sb_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
